// File: rtl/matmul_scratchpad.sv
// matmul_scratchpad: result matrix store with row write/accumulate, element reads, status and clear sequencer
module matmul_scratchpad #(
   parameter int DATA_WIDTH  = 8,
   parameter int BUS_WIDTH   = 32,
   parameter int SP_NTARGETS = 4,
   parameter int SATURATE    = 0,
   localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
   localparam int TW         = (SP_NTARGETS > 1) ? $clog2(SP_NTARGETS) : 1,
   localparam int IW         = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         eng_wr_valid_i,
   output logic                         eng_wr_ready_o,
   input  logic [TW-1:0]                eng_wr_target_i,
   input  logic [IW-1:0]                eng_wr_row_i,
   input  logic [MAX_DIM*BUS_WIDTH-1:0] eng_wr_data_i,
   input  logic                         eng_wr_acc_i,
   input  logic                         eng_wr_last_i,
   input  logic                         clr_i,
   input  logic [TW-1:0]                clr_target_i,
   input  logic                         rd_req_i,
   input  logic [TW-1:0]                rd_target_i,
   input  logic [IW-1:0]                rd_row_i,
   input  logic [IW-1:0]                rd_col_i,
   output logic                         rd_valid_o,
   output logic signed [BUS_WIDTH-1:0]  rd_data_o,
   output logic                         rd_err_o,
   output logic                         busy_o,
   output logic [SP_NTARGETS-1:0]       tgt_valid_o,
   output logic [SP_NTARGETS-1:0]       ovf_o
);
   typedef enum logic [1:0] {IDLE, ACC, CLEAR} state_e;
   typedef logic [MAX_DIM-1:0][BUS_WIDTH-1:0] row_t;
   state_e state_q, state_d;
   row_t mem_q [SP_NTARGETS][MAX_DIM];
   row_t data_q, st, acc_row;
   logic [TW-1:0] tgt_q, clr_tgt_q;
   logic [IW-1:0] row_q, cnt_q;
   logic last_q, acc_ovf, ov, wr_ok, acc_ok, clr_ok, clr_run_ok, rd_ok;
   logic [BUS_WIDTH:0] sum;
   logic [SP_NTARGETS-1:0] tgt_valid_q, ovf_q;
   logic rd_valid_q, rd_err_q;
   logic [BUS_WIDTH-1:0] rd_data_q;
   assign wr_ok = 32'(eng_wr_target_i) < SP_NTARGETS && 32'(eng_wr_row_i) < MAX_DIM;
   assign acc_ok = 32'(tgt_q) < SP_NTARGETS && 32'(row_q) < MAX_DIM;
   assign clr_ok = 32'(clr_target_i) < SP_NTARGETS;
   assign clr_run_ok = 32'(clr_tgt_q) < SP_NTARGETS;
   assign rd_ok = 32'(rd_target_i) < SP_NTARGETS && 32'(rd_row_i) < MAX_DIM && 32'(rd_col_i) < MAX_DIM;
   assign eng_wr_ready_o = rst_ni && state_q == IDLE && !clr_i;
   assign busy_o = state_q != IDLE;
   assign rd_valid_o = rd_valid_q;
   assign rd_data_o = rd_data_q;
   assign rd_err_o = rd_err_q;
   assign tgt_valid_o = tgt_valid_q;
   assign ovf_o = ovf_q;
   // next state: clear has priority over a write in IDLE, ACC is a single cycle, CLEAR walks all rows
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = clr_i ? CLEAR : (eng_wr_valid_i && eng_wr_acc_i) ? ACC : IDLE;
         ACC:     state_d = IDLE;
         CLEAR:   state_d = (cnt_q == IW'(MAX_DIM - 1)) ? IDLE : CLEAR;
         default: state_d = IDLE;
      endcase
   end
   // element-wise signed add of the captured row onto the stored row, with overflow detect and optional clamp
   always_comb begin
      st = acc_ok ? mem_q[tgt_q][row_q] : '0;
      acc_row = '0;
      acc_ovf = 1'b0;
      sum = '0;
      ov = 1'b0;
      for (int k = 0; k < MAX_DIM; k++) begin
         sum = {data_q[k][BUS_WIDTH-1], data_q[k]} + {st[k][BUS_WIDTH-1], st[k]};
         ov = sum[BUS_WIDTH] ^ sum[BUS_WIDTH-1];
         acc_ovf = acc_ovf | ov;
         acc_row[k] = (SATURATE != 0 && ov) ? (sum[BUS_WIDTH] ? {1'b1, {(BUS_WIDTH-1){1'b0}}} : {1'b0, {(BUS_WIDTH-1){1'b1}}}) : sum[BUS_WIDTH-1:0];
      end
   end
   // storage, status flags, accumulate/clear bookkeeping and the registered read port
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         for (int t = 0; t < SP_NTARGETS; t++)
            for (int r = 0; r < MAX_DIM; r++)
               mem_q[t][r] <= '0;
         data_q <= '0;
         tgt_q <= '0;
         row_q <= '0;
         last_q <= 1'b0;
         clr_tgt_q <= '0;
         cnt_q <= '0;
         tgt_valid_q <= '0;
         ovf_q <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q <= '0;
         rd_err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rd_valid_q <= rd_req_i;
         if (rd_req_i) begin
            rd_data_q <= rd_ok ? mem_q[rd_target_i][rd_row_i][rd_col_i] : '0;
            rd_err_q <= !rd_ok;
         end
         if (state_q == IDLE && clr_i) begin
            clr_tgt_q <= clr_target_i;
            cnt_q <= '0;
            if (clr_ok) begin
               tgt_valid_q[clr_target_i] <= 1'b0;
               ovf_q[clr_target_i] <= 1'b0;
            end
         end else if (state_q == IDLE && eng_wr_valid_i) begin
            if (eng_wr_acc_i) begin
               tgt_q <= eng_wr_target_i;
               row_q <= eng_wr_row_i;
               data_q <= eng_wr_data_i;
               last_q <= eng_wr_last_i;
            end else if (wr_ok) begin
               mem_q[eng_wr_target_i][eng_wr_row_i] <= eng_wr_data_i;
               if (eng_wr_last_i) tgt_valid_q[eng_wr_target_i] <= 1'b1;
            end
         end
         if (state_q == ACC && acc_ok) begin
            mem_q[tgt_q][row_q] <= acc_row;
            if (last_q) tgt_valid_q[tgt_q] <= 1'b1;
            if (acc_ovf) ovf_q[tgt_q] <= 1'b1;
         end
         if (state_q == CLEAR) begin
            if (clr_run_ok) mem_q[clr_tgt_q][cnt_q] <= '0;
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_matmul_scratchpad.sv
// tb_matmul_scratchpad: directed checks of a wrapping 4-target instance and a saturating 3-target instance
module tb_matmul_scratchpad;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic wv = 0, wa = 0, wl = 0, clr = 0, rq = 0;
   logic [1:0] wt = 0, wr = 0, ct = 0, rt = 0, rr = 0, rc = 0;
   logic [127:0] wd = 0;
   logic rdy0, rv0, re0, bsy0, rdy1, rv1, re1, bsy1;
   logic signed [31:0] rd0, rd1;
   logic [3:0] tv0, ov0;
   logic [2:0] tv1, ov1;
   int checks = 0;
   int errors = 0;
   always #5 clk = ~clk;
   matmul_scratchpad u0 (.clk_i(clk), .rst_ni(rst_n), .eng_wr_valid_i(wv), .eng_wr_ready_o(rdy0), .eng_wr_target_i(wt), .eng_wr_row_i(wr), .eng_wr_data_i(wd), .eng_wr_acc_i(wa), .eng_wr_last_i(wl), .clr_i(clr), .clr_target_i(ct), .rd_req_i(rq), .rd_target_i(rt), .rd_row_i(rr), .rd_col_i(rc), .rd_valid_o(rv0), .rd_data_o(rd0), .rd_err_o(re0), .busy_o(bsy0), .tgt_valid_o(tv0), .ovf_o(ov0));
   matmul_scratchpad #(.SP_NTARGETS(3), .SATURATE(1)) u1 (.clk_i(clk), .rst_ni(rst_n), .eng_wr_valid_i(wv), .eng_wr_ready_o(rdy1), .eng_wr_target_i(wt), .eng_wr_row_i(wr), .eng_wr_data_i(wd), .eng_wr_acc_i(wa), .eng_wr_last_i(wl), .clr_i(clr), .clr_target_i(ct), .rd_req_i(rq), .rd_target_i(rt), .rd_row_i(rr), .rd_col_i(rc), .rd_valid_o(rv1), .rd_data_o(rd1), .rd_err_o(re1), .busy_o(bsy1), .tgt_valid_o(tv1), .ovf_o(ov1));
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic drive_wr(input logic [1:0] t, input logic [1:0] r, input logic [127:0] d, input logic acc, input logic last);
      wv = 1; wt = t; wr = r; wd = d; wa = acc; wl = last;
   endtask
   task automatic drive_rd(input logic [1:0] t, input logic [1:0] r, input logic [1:0] c);
      rq = 1; rt = t; rr = r; rc = c;
   endtask
   task automatic test_reset();
      #3 rst_n = 0;
      tick(); tick();
      checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", rdy0); end
      checks++; if ({bsy0, rv0, re0, rd0} !== 35'd0) begin errors++; $display("FAIL reset_outs got %b%b%b %h want all 0", bsy0, rv0, re0, rd0); end
      checks++; if ({tv0, ov0} !== 8'd0) begin errors++; $display("FAIL reset_status got %b %b want 0 0", tv0, ov0); end
      rst_n = 1;
      drive_rd(0, 0, 0);
      tick();
      rq = 0;
      checks++; if (rv0 !== 1'b1 || rd0 !== 32'sd0) begin errors++; $display("FAIL reset_read got v=%b d=%h want v=1 d=0", rv0, rd0); end
      checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL idle_ready got %b want 1", rdy0); end
      tick();
      checks++; if (rv0 !== 1'b0) begin errors++; $display("FAIL rd_valid_drop got %b want 0", rv0); end
   endtask
   task automatic test_overwrite();
      drive_wr(1, 2, {32'sd1, 32'sd2, -32'sd3, 32'sd4}, 0, 1);
      #1;
      checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL ow_ready got %b want 1", rdy0); end
      tick();
      wv = 0;
      checks++; if (bsy0 !== 1'b0 || rdy0 !== 1'b1) begin errors++; $display("FAIL ow_busy got b=%b r=%b want 0 1", bsy0, rdy0); end
      checks++; if (tv0 !== 4'b0010 || tv1 !== 3'b010) begin errors++; $display("FAIL ow_tgt_valid got %b %b want 0010 010", tv0, tv1); end
      drive_rd(1, 2, 1);
      tick();
      rq = 0;
      checks++; if (rd0 !== -32'sd3 || rd1 !== -32'sd3) begin errors++; $display("FAIL ow_read got %h %h want fffffffd", rd0, rd1); end
   endtask
   task automatic test_accumulate();
      logic [31:0] exp_v [4] = '{32'd11, 32'd22, 32'd33, 32'd44};
      drive_wr(0, 1, {32'd4, 32'd3, 32'd2, 32'd1}, 0, 0);
      tick();
      drive_wr(0, 1, {32'd40, 32'd30, 32'd20, 32'd10}, 1, 0);
      #1;
      checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL acc_ready_pre got %b want 1", rdy0); end
      tick();
      wv = 0;
      checks++; if (rdy0 !== 1'b0 || bsy0 !== 1'b1) begin errors++; $display("FAIL acc_cycle got r=%b b=%b want 0 1", rdy0, bsy0); end
      tick();
      checks++; if (rdy0 !== 1'b1 || bsy0 !== 1'b0) begin errors++; $display("FAIL acc_done got r=%b b=%b want 1 0", rdy0, bsy0); end
      for (int c = 0; c < 4; c++) begin
         drive_rd(0, 1, 2'(c));
         tick();
         checks++; if (rd0 !== exp_v[c]) begin errors++; $display("FAIL acc_elem%0d got %0d want %0d", c, rd0, exp_v[c]); end
      end
      rq = 0;
      checks++; if (tv0 !== 4'b0010 || ov0 !== 4'b0000) begin errors++; $display("FAIL acc_status got %b %b want 0010 0000", tv0, ov0); end
   endtask
   task automatic test_overflow();
      drive_wr(2, 0, {96'd0, 32'h7FFFFFFF}, 0, 0);
      tick();
      drive_wr(2, 0, {96'd0, 32'd1}, 1, 1);
      tick();
      wv = 0;
      tick();
      drive_rd(2, 0, 0);
      tick();
      rq = 0;
      checks++; if (rd0 !== 32'sh80000000) begin errors++; $display("FAIL ovf_wrap got %h want 80000000", rd0); end
      checks++; if (rd1 !== 32'sh7FFFFFFF) begin errors++; $display("FAIL ovf_sat got %h want 7fffffff", rd1); end
      checks++; if (ov0 !== 4'b0100 || ov1 !== 3'b100) begin errors++; $display("FAIL ovf_flag got %b %b want 0100 100", ov0, ov1); end
      checks++; if (tv0 !== 4'b0110 || tv1 !== 3'b110) begin errors++; $display("FAIL ovf_tgt_valid got %b %b want 0110 110", tv0, tv1); end
   endtask
   task automatic test_clear();
      clr = 1; ct = 2;
      drive_wr(3, 0, {4{32'd77}}, 0, 1);
      #1;
      checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL clr_ready got %b want 0", rdy0); end
      tick();
      clr = 0; wv = 0;
      checks++; if (tv0 !== 4'b0010 || ov0 !== 4'b0000 || tv1 !== 3'b010 || ov1 !== 3'b000) begin errors++; $display("FAIL clr_status got %b %b %b %b want 0010 0000 010 000", tv0, ov0, tv1, ov1); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (bsy0 !== 1'b1) begin errors++; $display("FAIL clr_busy%0d got %b want 1", i, bsy0); end
         tick();
      end
      checks++; if (bsy0 !== 1'b0 || rdy0 !== 1'b1) begin errors++; $display("FAIL clr_end got b=%b r=%b want 0 1", bsy0, rdy0); end
      drive_rd(2, 0, 0);
      tick();
      checks++; if (rd0 !== 32'sd0 || rd1 !== 32'sd0) begin errors++; $display("FAIL clr_data got %h %h want 0 0", rd0, rd1); end
      drive_rd(3, 0, 0);
      tick();
      rq = 0;
      checks++; if (rd0 !== 32'sd0) begin errors++; $display("FAIL clr_write_blocked got %h want 0", rd0); end
   endtask
   task automatic test_back_to_back();
      drive_wr(1, 2, {4{32'd7}}, 0, 0);
      drive_rd(1, 2, 1);
      tick();
      checks++; if (rd0 !== -32'sd3) begin errors++; $display("FAIL b2b_collide got %h want fffffffd", rd0); end
      checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b want 1", rdy0); end
      drive_wr(1, 3, {4{32'd9}}, 0, 0);
      tick();
      wv = 0;
      checks++; if (rd0 !== 32'sd7) begin errors++; $display("FAIL b2b_new got %0d want 7", rd0); end
      drive_rd(1, 3, 3);
      tick();
      rq = 0;
      checks++; if (rd0 !== 32'sd9 || rd1 !== 32'sd9) begin errors++; $display("FAIL b2b_second got %0d %0d want 9 9", rd0, rd1); end
   endtask
   task automatic test_out_of_range();
      drive_wr(3, 0, {4{32'd5}}, 0, 1);
      tick();
      wv = 0;
      checks++; if (tv0 !== 4'b1010 || tv1 !== 3'b010) begin errors++; $display("FAIL oor_tgt_valid got %b %b want 1010 010", tv0, tv1); end
      drive_rd(3, 0, 0);
      tick();
      rq = 0;
      checks++; if (rd0 !== 32'sd5 || re0 !== 1'b0) begin errors++; $display("FAIL oor_inrange got d=%0d e=%b want 5 0", rd0, re0); end
      checks++; if (rd1 !== 32'sd0 || re1 !== 1'b1 || rv1 !== 1'b1) begin errors++; $display("FAIL oor_read got d=%0d e=%b v=%b want 0 1 1", rd1, re1, rv1); end
      tick();
      checks++; if (rd0 !== 32'sd5 || rv0 !== 1'b0) begin errors++; $display("FAIL rd_hold got d=%0d v=%b want 5 0", rd0, rv0); end
   endtask
   task automatic test_reset_mid_clear();
      clr = 1; ct = 1;
      drive_rd(3, 0, 0);
      tick();
      clr = 0;
      tick();
      checks++; if (bsy0 !== 1'b1 || rv0 !== 1'b1 || rd0 !== 32'sd5) begin errors++; $display("FAIL pre_rst got b=%b v=%b d=%0d want 1 1 5", bsy0, rv0, rd0); end
      rst_n = 0; rq = 0;
      #1;
      checks++; if ({bsy0, rdy0, rv0, re0, rd0} !== 36'd0 || {tv0, ov0} !== 8'd0) begin errors++; $display("FAIL mid_rst got b=%b r=%b v=%b e=%b d=%h tv=%b ov=%b want all 0", bsy0, rdy0, rv0, re0, rd0, tv0, ov0); end
      tick();
      rst_n = 1;
      drive_rd(3, 0, 0);
      tick();
      drive_rd(1, 3, 3);
      checks++; if (rd0 !== 32'sd0 || rv0 !== 1'b1) begin errors++; $display("FAIL post_rst_t3 got d=%0d v=%b want 0 1", rd0, rv0); end
      tick();
      rq = 0;
      checks++; if (rd0 !== 32'sd0 || bsy0 !== 1'b0) begin errors++; $display("FAIL post_rst_t1 got d=%0d b=%b want 0 0", rd0, bsy0); end
   endtask
   initial begin
      test_reset();
      test_overwrite();
      test_accumulate();
      test_overflow();
      test_clear();
      test_back_to_back();
      test_out_of_range();
      test_reset_mid_clear();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
